// File: rtl/ztimer_pkg.sv
// Shared types and sizing helpers for the ztimer capture array.
package ztimer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } zt_state_e;

   localparam int ZT_BYTE_W = 8;

   function automatic int zt_num_bytes(input int cnt_w);
      return (cnt_w + 7) / 8;
   endfunction

endpackage

// File: rtl/ztimer_channel.sv
// One timer channel: optional input synchroniser (ZTIMER_SYNC_EN), edge detect,
// IDLE/RUN/DONE state machine and saturating counter.
module ztimer_channel
   import ztimer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic start_s;
   logic stop_s;
   logic clear_s;

`ifdef ZTIMER_SYNC_EN
   logic [1:0] start_sync_r;
   logic [1:0] stop_sync_r;
   logic [1:0] clear_sync_r;

   // Two-flop synchronisers for the control inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_sync_r <= 2'b00;
         stop_sync_r  <= 2'b00;
         clear_sync_r <= 2'b00;
      end else begin
         start_sync_r <= {start_sync_r[0], start};
         stop_sync_r  <= {stop_sync_r[0], stop};
         clear_sync_r <= {clear_sync_r[0], clear};
      end
   end

   assign start_s = start_sync_r[1];
   assign stop_s  = stop_sync_r[1];
   assign clear_s = clear_sync_r[1];
`else
   assign start_s = start;
   assign stop_s  = stop;
   assign clear_s = clear;
`endif

   logic             start_q_r;
   logic             stop_q_r;
   logic             start_rise_s;
   logic             stop_rise_s;
   zt_state_e        state_r;
   zt_state_e        state_nx_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nx_s;
   logic             ovf_r;
   logic             ovf_nx_s;
   logic             busy_r;
   logic             done_r;

   assign start_rise_s = start_s & ~start_q_r;
   assign stop_rise_s  = stop_s & ~stop_q_r;

   // Next-state, counter and overflow logic; clear overrides every state.
   always_comb begin
      state_nx_s = state_r;
      count_nx_s = count_r;
      ovf_nx_s   = ovf_r;
      if (clear_s) begin
         state_nx_s = ST_IDLE;
         count_nx_s = '0;
         ovf_nx_s   = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A coincident stop rise is dropped: start wins.
               if (start_rise_s) begin
                  state_nx_s = ST_RUN;
                  count_nx_s = '0;
                  ovf_nx_s   = 1'b0;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (count_r == CNT_MAX) begin
                  ovf_nx_s = 1'b1;
               end else begin
                  count_nx_s = count_r + CNT_W'(1);
               end
               if (stop_rise_s) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
            ST_DONE: begin
               state_nx_s = ST_DONE;
            end
            default: begin
               state_nx_s = ST_IDLE;
               count_nx_s = '0;
               ovf_nx_s   = 1'b0;
            end
         endcase
      end
   end

   // State, counter, edge-detect history and status flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         count_r   <= '0;
         ovf_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         start_q_r <= 1'b0;
         stop_q_r  <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         count_r   <= count_nx_s;
         ovf_r     <= ovf_nx_s;
         busy_r    <= (state_nx_s == ST_RUN);
         done_r    <= (state_nx_s == ST_DONE);
         start_q_r <= start_s;
         stop_q_r  <= stop_s;
      end
   end

   assign count = count_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign ovf   = ovf_r;

endmodule

// File: rtl/ztimer_capture_array.sv
// Multi-channel interval timer with a byte-wide request/ack readout port.
// Optional input synchronisation is enabled with ZTIMER_SYNC_EN.
module ztimer_capture_array
   import ztimer_pkg::*;
#(
   parameter  int NCH    = 4,
   parameter  int CNT_W  = 32,
   localparam int NB     = zt_num_bytes(CNT_W),
   localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       clear,
   input  logic [NCH-1:0]       start,
   input  logic [NCH-1:0]       stop,
   input  logic                 rd_req,
   input  logic [SEL_W-1:0]     rd_sel,
   input  logic [BYTE_W-1:0]    rd_byte,
   output logic                 rd_ack,
   output logic [ZT_BYTE_W-1:0] rd_data,
   output logic [NCH-1:0]       busy,
   output logic [NCH-1:0]       done,
   output logic [NCH-1:0]       ovf
);

   logic [NCH-1:0][CNT_W-1:0]    counts_s;
   logic [CNT_W-1:0]             sel_cnt_s;
   logic [NB*ZT_BYTE_W-1:0]      padded_s;
   logic [ZT_BYTE_W-1:0]         byte_s;
   logic                         rd_ack_r;
   logic [ZT_BYTE_W-1:0]         rd_data_r;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      ztimer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .clear (clear[g]),
         .start (start[g]),
         .stop  (stop[g]),
         .count (counts_s[g]),
         .busy  (busy[g]),
         .done  (done[g]),
         .ovf   (ovf[g])
      );
   end

   // Readout mux; selectors that match no channel or byte fall through to zero.
   always_comb begin
      sel_cnt_s = '0;
      for (int c = 0; c < NCH; c++) begin
         if (rd_sel == SEL_W'(c)) begin
            sel_cnt_s = counts_s[c];
         end else begin
            sel_cnt_s = sel_cnt_s;
         end
      end
      padded_s = '0;
      padded_s[CNT_W-1:0] = sel_cnt_s;
      byte_s = 8'h00;
      for (int b = 0; b < NB; b++) begin
         if (rd_byte == BYTE_W'(b)) begin
            byte_s = padded_s[b*ZT_BYTE_W +: ZT_BYTE_W];
         end else begin
            byte_s = byte_s;
         end
      end
   end

   // Readout register: one ack per request cycle, data held between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ack_r  <= 1'b0;
         rd_data_r <= 8'h00;
      end else begin
         rd_ack_r <= rd_req;
         if (rd_req) begin
            rd_data_r <= byte_s;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_ack  = rd_ack_r;
   assign rd_data = rd_data_r;

endmodule

// File: tb/tb_ztimer_capture_array.sv
// Directed self-checking bench: a 4x32-bit array plus a 1x8-bit array for saturation.
module tb_ztimer_capture_array;

`ifdef ZTIMER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] clear, start, stop;
   logic       rd_req;
   logic [1:0] rd_sel, rd_byte;
   logic       rd_ack;
   logic [7:0] rd_data;
   logic [3:0] busy, done, ovf;

   logic [0:0] clear8, start8, stop8;
   logic       rd_req8;
   logic [0:0] rd_sel8, rd_byte8;
   logic       rd_ack8;
   logic [7:0] rd_data8;
   logic [0:0] busy8, done8, ovf8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ztimer_capture_array #(.NCH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_byte(rd_byte),
      .rd_ack(rd_ack), .rd_data(rd_data), .busy(busy), .done(done), .ovf(ovf)
   );

   ztimer_capture_array #(.NCH(1), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .clear(clear8), .start(start8), .stop(stop8),
      .rd_req(rd_req8), .rd_sel(rd_sel8), .rd_byte(rd_byte8),
      .rd_ack(rd_ack8), .rd_data(rd_data8), .busy(busy8), .done(done8), .ovf(ovf8)
   );

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] sel, input logic [1:0] byt, output logic [7:0] d);
      rd_req = 1'b1; rd_sel = sel; rd_byte = byt;
      cyc(1);
      rd_req = 1'b0;
      chk("rd_ack", 64'(rd_ack), 64'd1);
      d = rd_data;
   endtask

   task automatic rd_cnt(input logic [1:0] ch, output logic [31:0] v);
      logic [7:0] d;
      for (int b = 0; b < 4; b++) begin
         rd(ch, 2'(b), d);
         v[b*8 +: 8] = d;
      end
   endtask

   task automatic rd8(input logic [0:0] sel, input logic [0:0] byt, output logic [7:0] d);
      rd_req8 = 1'b1; rd_sel8 = sel; rd_byte8 = byt;
      cyc(1);
      rd_req8 = 1'b0;
      chk("rd_ack8", 64'(rd_ack8), 64'd1);
      d = rd_data8;
   endtask

   initial begin
      logic [7:0]  d, d1, d2;
      logic [31:0] v;

      rst = 1'b1; clear = 4'h0; start = 4'h0; stop = 4'h0;
      rd_req = 1'b0; rd_sel = 2'd0; rd_byte = 2'd0;
      clear8 = 1'b0; start8 = 1'b0; stop8 = 1'b0;
      rd_req8 = 1'b0; rd_sel8 = 1'b0; rd_byte8 = 1'b0;
      cyc(3);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_done", 64'(done), 64'h0);
      chk("reset_ovf", 64'(ovf), 64'h0);
      chk("reset_ack", 64'(rd_ack), 64'h0);
      chk("reset_data", 64'(rd_data), 64'h0);
      rst = 1'b0;
      cyc(2);

      // Single channel: interval of 100 cycles.
      start[0] = 1'b1; cyc(1); start[0] = 1'b0; cyc(LAT);
      chk("ch0_busy", 64'(busy), 64'h1);
      cyc(99); stop[0] = 1'b1; cyc(1); stop[0] = 1'b0; cyc(LAT);
      chk("ch0_done", 64'(done), 64'h1);
      chk("ch0_busy_off", 64'(busy), 64'h0);
      rd(2'd0, 2'd0, d); chk("ch0_b0", 64'(d), 64'h64);
      rd(2'd0, 2'd1, d); chk("ch0_b1", 64'(d), 64'h00);
      rd(2'd0, 2'd2, d); chk("ch0_b2", 64'(d), 64'h00);
      rd(2'd0, 2'd3, d); chk("ch0_b3", 64'(d), 64'h00);
      cyc(1);
      chk("ack_single", 64'(rd_ack), 64'h0);

      // Clear returns the channel to IDLE with a zero count.
      clear[0] = 1'b1; cyc(1); clear[0] = 1'b0; cyc(LAT);
      chk("ch0_clear_done", 64'(done), 64'h0);
      rd_cnt(2'd0, v); chk("ch0_clear_cnt", 64'(v), 64'd0);

      // Start and stop on the same edge: start wins, later stop measures 5.
      start[1] = 1'b1; stop[1] = 1'b1; cyc(1); start[1] = 1'b0; stop[1] = 1'b0; cyc(LAT);
      chk("ch1_same_edge_busy", 64'(busy), 64'h2);
      cyc(4 - LAT); stop[1] = 1'b1; cyc(1); stop[1] = 1'b0; cyc(LAT);
      chk("ch1_done", 64'(done), 64'h2);
      rd_cnt(2'd1, v); chk("ch1_cnt", 64'(v), 64'd5);

      // Clear and start on the same edge: clear wins; release does not start.
      clear[2] = 1'b1; start[2] = 1'b1; cyc(1); clear[2] = 1'b0; cyc(LAT);
      chk("ch2_clear_start_busy", 64'(busy[2]), 64'h0);
      cyc(3);
      chk("ch2_after_release", 64'(busy[2]), 64'h0);
      rd_cnt(2'd2, v); chk("ch2_cnt", 64'(v), 64'd0);
      start[2] = 1'b0;

      // Live read of a running channel with rd_req held for two cycles.
      start[3] = 1'b1; cyc(1); start[3] = 1'b0; cyc(LAT);
      rd_req = 1'b1; rd_sel = 2'd3; rd_byte = 2'd0;
      cyc(1); chk("live_ack1", 64'(rd_ack), 64'h1); d1 = rd_data;
      cyc(1); chk("live_ack2", 64'(rd_ack), 64'h1); d2 = rd_data;
      rd_req = 1'b0;
      chk("live_first", 64'(d1), 64'h00);
      chk("live_delta", 64'(d2 - d1), 64'h01);
      cyc(1);
      chk("live_ack_drop", 64'(rd_ack), 64'h0);

      clear = 4'hF; cyc(1); clear = 4'h0; cyc(LAT + 1);
      chk("clear_all", 64'({busy, done}), 64'h0);

      // Overlapping intervals 7, 300, 65536, 1 on channels 0..3.
      start = 4'hF; cyc(1); start = 4'h0;
      stop = 4'b1000; cyc(1); stop = 4'h0;
      cyc(5);     stop = 4'b0001; cyc(1); stop = 4'h0;
      cyc(292);   stop = 4'b0010; cyc(1); stop = 4'h0;
      cyc(65235); stop = 4'b0100; cyc(1); stop = 4'h0;
      cyc(LAT);
      chk("ovl_done", 64'(done), 64'hF);
      chk("ovl_ovf", 64'(ovf), 64'h0);
      rd_cnt(2'd0, v); chk("ovl_cnt0", 64'(v), 64'd7);
      rd_cnt(2'd1, v); chk("ovl_cnt1", 64'(v), 64'd300);
      rd_cnt(2'd2, v); chk("ovl_cnt2", 64'(v), 64'd65536);
      rd_cnt(2'd3, v); chk("ovl_cnt3", 64'(v), 64'd1);

      // 8-bit saturation and out-of-range reads.
      start8 = 1'b1; cyc(1); start8 = 1'b0; cyc(LAT);
      cyc(255);
      chk("sat_ovf_pre", 64'(ovf8), 64'h0);
      rd8(1'b0, 1'b0, d); chk("sat_255", 64'(d), 64'hFF);
      chk("sat_ovf", 64'(ovf8), 64'h1);
      cyc(44);
      rd8(1'b0, 1'b0, d); chk("sat_hold", 64'(d), 64'hFF);
      stop8 = 1'b1; cyc(1); stop8 = 1'b0; cyc(LAT);
      chk("sat_done", 64'(done8), 64'h1);
      chk("sat_ovf_done", 64'(ovf8), 64'h1);
      rd8(1'b0, 1'b0, d); chk("sat_final", 64'(d), 64'hFF);
      rd8(1'b1, 1'b0, d); chk("oor_sel", 64'(d), 64'h00);
      rd8(1'b0, 1'b1, d); chk("oor_byte", 64'(d), 64'h00);

      // Reset aborts two running channels.
      clear = 4'hF; cyc(1); clear = 4'h0; cyc(LAT + 1);
      start = 4'b0011; cyc(1); start = 4'h0; cyc(LAT + 3);
      chk("rst_pre_busy", 64'(busy), 64'h3);
      rst = 1'b1; rd_req = 1'b1; rd_sel = 2'd0; rd_byte = 2'd0;
      cyc(1);
      rst = 1'b0; rd_req = 1'b0;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ack", 64'(rd_ack), 64'h0);
      chk("rst_data", 64'(rd_data), 64'h0);
      rd_cnt(2'd0, v); chk("rst_cnt0", 64'(v), 64'd0);
      rd_cnt(2'd1, v); chk("rst_cnt1", 64'(v), 64'd0);
      start[0] = 1'b1; cyc(1); start[0] = 1'b0;
      cyc(2); stop[0] = 1'b1; cyc(1); stop[0] = 1'b0; cyc(LAT);
      rd_cnt(2'd0, v); chk("fresh_cnt", 64'(v), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
